// File: rtl/marvin_gfx_pkg.sv
// Shared definitions for the framebuffer scanout path.
//   fetch_state_t : line-prefetch FSM states
//   DEF_WIDTH/DEF_HEIGHT : default visible raster (800x600)
//   FB_ADDR_W     : default framebuffer word address width
//   idx_bits()    : index width needed to address n entries (min 1)
package marvin_gfx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    localparam int DEF_WIDTH  = 800;
    localparam int DEF_HEIGHT = 600;
    localparam int FB_ADDR_W  = 19;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Ping-pong line buffer: two banks of WIDTH pixels.
//   clk                         : clock
//   wr_en/wr_bank/wr_idx/wr_data: synchronous write port
//   rd_bank/rd_idx              : read address, sampled on clk
//   rd_data                     : registered read data (1-cycle latency)
module line_buffer
    import marvin_gfx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int COL_W = 16,
    parameter int IDX_W = idx_bits(WIDTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [COL_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [COL_W-1:0] rd_data
);

    logic [COL_W-1:0] mem [2][WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
        rd_data <= mem[rd_bank][rd_idx];
    end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Arbitrates a single-port framebuffer SRAM between line prefetch for VGA
// scanout (always wins) and a valid/ready pixel writer, and serves the
// front line-buffer bank as the VGA colour.
//   clk, res              : clock, async active-high reset
//   line_req, line_y      : swap banks and fetch line line_y
//   pix_x -> color        : front-bank pixel, 1-cycle latency
//   wr_valid/wr_ready, wr_addr, wr_data : writer handshake
//   mem_addr, mem_we, mem_wdata, mem_rdata : SRAM port (rdata 1 cycle late)
//   fetch_busy, underrun, wr_drop : status
module fb_scanout_arbiter
    import marvin_gfx_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int COL_W  = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              line_req,
    input  logic [15:0]       line_y,
    input  logic [15:0]       pix_x,
    output logic [COL_W-1:0]  color,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COL_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [COL_W-1:0]  mem_wdata,
    input  logic [COL_W-1:0]  mem_rdata,
    output logic              fetch_busy,
    output logic              underrun,
    output logic              wr_drop
);

    localparam int               IDX_W    = idx_bits(WIDTH);
    localparam int               AW1      = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [AW1-1:0]   FB_WORDS = AW1'(WIDTH * HEIGHT);

    fetch_state_t      state;
    logic              front;
    logic [1:0]        blank;
    logic [IDX_W-1:0]  cur_idx;
    logic              rd_pend;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_bank;
    logic              show;
    logic [COL_W-1:0]  lb_q;

    logic              pix_in_range;
    logic              y_in_range;
    logic              wr_in_range;
    logic              wr_accept;
    logic [IDX_W-1:0]  pix_idx;
    logic [ADDR_W-1:0] fetch_base;

    assign pix_in_range = pix_x < 16'(WIDTH);
    assign y_in_range   = line_y < 16'(HEIGHT);
    assign wr_in_range  = {1'b0, wr_addr} < FB_WORDS;
    assign pix_idx      = pix_in_range ? pix_x[IDX_W-1:0] : '0;
    assign fetch_base   = ADDR_W'(line_y) * ADDR_W'(WIDTH);

    assign wr_ready  = (state != FETCH) && !line_req;
    assign wr_accept = wr_valid && wr_ready;

    // The buffer read is already registered, so gating it with a registered
    // visibility flag keeps the colour at one cycle of latency.
    assign color = show ? lb_q : '0;

    line_buffer #(
        .WIDTH (WIDTH),
        .COL_W (COL_W),
        .IDX_W (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (rd_pend),
        .wr_bank (rd_bank),
        .wr_idx  (rd_idx),
        .wr_data (mem_rdata),
        .rd_bank (front),
        .rd_idx  (pix_idx),
        .rd_data (lb_q)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            front      <= 1'b0;
            blank      <= '1;
            cur_idx    <= '0;
            rd_pend    <= 1'b0;
            rd_idx     <= '0;
            rd_bank    <= 1'b0;
            show       <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            fetch_busy <= 1'b0;
            underrun   <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            wr_drop  <= 1'b0;
            mem_we   <= 1'b0;
            show     <= pix_in_range && !blank[front];

            // Word addressed now returns next cycle; a new line_req squashes
            // it so an aborted fetch never writes into the bank being shown.
            rd_pend <= (state == FETCH) && !line_req;
            rd_idx  <= cur_idx;
            rd_bank <= ~front;

            if (line_req) begin
                // The new back bank is the one currently in front.
                front    <= ~front;
                underrun <= (state != IDLE);
                if (y_in_range) begin
                    blank[front] <= 1'b0;
                    state        <= FETCH;
                    fetch_busy   <= 1'b1;
                    cur_idx      <= '0;
                    mem_addr     <= fetch_base;
                end else begin
                    blank[front] <= 1'b1;
                    state        <= IDLE;
                    fetch_busy   <= 1'b0;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (cur_idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            cur_idx  <= cur_idx + 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        state      <= IDLE;
                        fetch_busy <= 1'b0;
                    end
                    default: ;
                endcase

                if (wr_accept) begin
                    if (wr_in_range) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                    end else begin
                        wr_drop <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Self-checking bench for fb_scanout_arbiter at WIDTH=8, HEIGHT=4, with an
// SRAM model preloaded with mem[a]=a.
module tb_fb_scanout_arbiter;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 6;

    logic          clk;
    logic          res;
    logic          line_req;
    logic [15:0]   line_y;
    logic [15:0]   pix_x;
    logic [15:0]   color;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          fetch_busy;
    logic          underrun;
    logic          wr_drop;

    fb_scanout_arbiter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW),
        .COL_W  (16)
    ) dut (
        .clk        (clk),
        .res        (res),
        .line_req   (line_req),
        .line_y     (line_y),
        .pix_x      (pix_x),
        .color      (color),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fetch_busy (fetch_busy),
        .underrun   (underrun),
        .wr_drop    (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: synchronous read, one cycle latency.
    logic [15:0] sram [64];
    initial begin
        for (int a = 0; a < 64; a++) sram[a] = 16'(a);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_we) sram[mem_addr] <= mem_wdata;
            mem_rdata <= sram[mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: framebuffer image, bank contents, and the current
    // fetch described by its start cycle and a snapshot of the line.
    logic [15:0]   fb     [64];
    logic [15:0]   m_bank [2][W];
    logic [15:0]   snap   [W];
    logic          m_front;
    logic [1:0]    m_blank;
    logic          m_act;
    logic          m_back;
    int            m_s;
    int            m_base;

    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [15:0]   e_wdata;
    logic          e_busy;
    logic          e_under;
    logic          e_drop;
    logic [15:0]   e_color;
    logic          rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Words of the current fetch that reached the back bank: n of them.
    task automatic settle_fetch(input int n);
        int k;
        if (m_act) begin
            k = (n < 0) ? 0 : ((n > W) ? W : n);
            for (int i = 0; i < k; i++) m_bank[m_back][i] = snap[i];
            m_act = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_front = 1'b0;
        m_blank = 2'b11;
        m_act   = 1'b0;
        m_s     = -1000;
        e_addr  = '0;
        e_we    = 1'b0;
        e_wdata = '0;
        e_busy  = 1'b0;
        e_under = 1'b0;
        e_drop  = 1'b0;
        e_color = '0;
    endtask

    // One clock cycle: drive inputs, check wr_ready, predict, check outputs.
    task automatic step(input logic lr, input logic [15:0] ly, input logic [15:0] px,
                        input logic wv, input logic [AW-1:0] wa, input logic [15:0] wd,
                        output logic rdy_o);
        int   off_now, off_nxt;
        logic fetching, busy_now, acc;
        line_req = lr;
        line_y   = ly;
        pix_x    = px;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        off_now  = cyc - m_s;
        fetching = m_act && off_now >= 1 && off_now <= W;
        busy_now = m_act && off_now >= 1 && off_now <= W + 1;
        acc      = wv && !fetching && !lr;
        #1;
        rdy_o = wr_ready;
        chk("wr_ready", 32'(wr_ready), 32'(!fetching && !lr));
        @(posedge clk);
        if (px < 16'(W) && !m_blank[m_front]) e_color = m_bank[m_front][px[2:0]];
        else e_color = '0;
        e_under = lr && busy_now;
        e_drop  = acc && (int'(wa) >= W * H);
        e_we    = acc && (int'(wa) < W * H);
        if (e_we) begin
            e_addr  = wa;
            e_wdata = wd;
            fb[wa]  = wd;
        end
        if (lr) begin
            settle_fetch(cyc - m_s - 1);
            m_back  = m_front;
            m_front = !m_front;
            if (int'(ly) < H) begin
                m_blank[m_back] = 1'b0;
                m_act  = 1'b1;
                m_s    = cyc;
                m_base = int'(ly) * W;
                for (int i = 0; i < W; i++) snap[i] = fb[m_base + i];
            end else begin
                m_blank[m_back] = 1'b1;
            end
        end
        off_nxt = cyc + 1 - m_s;
        if (m_act && off_nxt >= 1 && off_nxt <= W) e_addr = AW'(m_base + off_nxt - 1);
        e_busy = m_act && off_nxt >= 1 && off_nxt <= W + 1;
        cyc++;
        @(negedge clk);
        chk("mem_addr",   32'(mem_addr),   32'(e_addr));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
        chk("fetch_busy", 32'(fetch_busy), 32'(e_busy));
        chk("underrun",   32'(underrun),   32'(e_under));
        chk("wr_drop",    32'(wr_drop),    32'(e_drop));
        chk("color",      32'(color),      32'(e_color));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'(i % 12), 1'b0, '0, '0, rdy);
    endtask

    task automatic reset_checks();
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
        chk("rst_underrun",   32'(underrun),   32'd0);
        chk("rst_wr_drop",    32'(wr_drop),    32'd0);
        chk("rst_color",      32'(color),      32'd0);
    endtask

    // Asserted mid-cycle, so words landing at earlier edges are kept.
    task automatic reset_mid();
        settle_fetch(cyc - m_s - 2);
        res      = 1'b1;
        line_req = 1'b0;
        wr_valid = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        res = 1'b0;
        model_reset();
    endtask

    initial begin
        res = 1'b1; line_req = 0; line_y = 0; pix_x = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        for (int a = 0; a < 64; a++) fb[a] = 16'(a);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < W; i++) m_bank[b][i] = 'x;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks();
        res = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        idle(2);

        // Fetch line 2: addresses 16..23 on T+1..T+8, busy drops at T+10.
        step(1'b1, 16'd2, 16'd0, 1'b0, '0, '0, rdy);
        chk("fetch_first_addr", 32'(mem_addr), 32'd16);
        chk("fetch_busy_hi", 32'(fetch_busy), 32'd1);
        for (int k = 1; k < W; k++) begin
            idle(1);
            chk("fetch_addr", 32'(mem_addr), 32'(16 + k));
        end
        idle(1);
        chk("drain_busy", 32'(fetch_busy), 32'd1);
        idle(1);
        chk("busy_fall", 32'(fetch_busy), 32'd0);

        // Out-of-range line swaps line 2 in and blanks the new back bank.
        step(1'b1, 16'd4, 16'd3, 1'b0, '0, '0, rdy);
        step(1'b0, 16'd0, 16'd3, 1'b0, '0, '0, rdy);
        chk("color_px3", 32'(color), 32'd19);
        chk("oor_no_addr", 32'(mem_addr), 32'd23);
        chk("oor_not_busy", 32'(fetch_busy), 32'd0);
        step(1'b1, 16'd1, 16'd3, 1'b0, '0, '0, rdy);
        for (int p = 0; p < 10; p++) begin
            step(1'b0, 16'd0, 16'(p), 1'b0, '0, '0, rdy);
            chk("blank_color", 32'(color), 32'd0);
        end
        idle(2);

        // Write held across line_req waits for DRAIN.
        step(1'b1, 16'd0, 16'd0, 1'b1, 6'd5, 16'hABCD, rdy);
        chk("wr_blocked_lr", 32'(rdy), 32'd0);
        for (int k = 1; k <= W; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1, 6'd5, 16'hABCD, rdy);
            chk("wr_blocked_fetch", 32'(rdy), 32'd0);
        end
        step(1'b0, 16'd0, 16'd0, 1'b1, 6'd5, 16'hABCD, rdy);
        chk("wr_accept_drain", 32'(rdy), 32'd1);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'd5);
        chk("wr_data", 32'(mem_wdata), 32'hABCD);
        idle(3);

        // Underrun: second line_req four cycles into the fetch.
        step(1'b1, 16'd1, 16'd0, 1'b0, '0, '0, rdy);
        idle(3);
        step(1'b1, 16'd2, 16'd0, 1'b0, '0, '0, rdy);
        chk("underrun_pulse", 32'(underrun), 32'd1);
        chk("restart_addr", 32'(mem_addr), 32'd16);
        idle(1);
        chk("underrun_once", 32'(underrun), 32'd0);
        chk("restart_addr2", 32'(mem_addr), 32'd17);
        idle(12);

        // Out-of-range write is dropped.
        step(1'b0, 16'd0, 16'd0, 1'b1, 6'd40, 16'h1234, rdy);
        chk("drop_accepted", 32'(rdy), 32'd1);
        chk("drop_pulse", 32'(wr_drop), 32'd1);
        chk("drop_no_we", 32'(mem_we), 32'd0);
        idle(1);
        chk("drop_once", 32'(wr_drop), 32'd0);

        // Reset in the middle of a fetch.
        step(1'b1, 16'd3, 16'd0, 1'b0, '0, '0, rdy);
        idle(3);
        reset_mid();
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            logic          lr, wv;
            logic [15:0]   ly, px, wd;
            logic [AW-1:0] wa;
            if (i == 1500) begin
                idle(1);
                reset_mid();
            end
            lr = ($urandom_range(0, 11) == 0);
            ly = 16'($urandom_range(0, 5));
            px = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 11));
            wv = ($urandom_range(0, 2) != 0);
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(32, 63)) : AW'($urandom_range(0, 31));
            wd = 16'($urandom);
            step(lr, ly, px, wv, wa, wd, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
